// File: rtl/oa_sparse_encoder_if.sv
// Activation-stream, tile-control and oaram-write signals of the sparse encoder.
// The master drives tile control and activations; the slave (encoder) drives oaram writes and status.
interface oa_sparse_encoder_if #(
  parameter int DATA_WIDTH  = 8,
  parameter int INDEX_WIDTH = 4,
  parameter int ADDR_WIDTH  = 10
);
  logic                   start;
  logic [ADDR_WIDTH-1:0]  base_addr;
  logic                   in_valid;
  logic                   in_ready;
  logic [DATA_WIDTH-1:0]  in_value;
  logic                   in_last;
  logic [DATA_WIDTH-1:0]  oaram_value;
  logic [INDEX_WIDTH-1:0] oaram_indices_value;
  logic [ADDR_WIDTH-1:0]  oaram_address;
  logic                   oaram_write_enable;
  logic                   done;
  logic [ADDR_WIDTH:0]    entry_count;
  logic                   overflow;

  modport master (
    output start, base_addr, in_valid, in_value, in_last,
    input  in_ready, oaram_value, oaram_indices_value, oaram_address,
           oaram_write_enable, done, entry_count, overflow
  );

  modport slave (
    input  start, base_addr, in_valid, in_value, in_last,
    output in_ready, oaram_value, oaram_indices_value, oaram_address,
           oaram_write_enable, done, entry_count, overflow
  );
endinterface

// File: rtl/oa_sparse_encoder.sv
// Compresses a dense post-ReLU activation tile into (value, zero-run) pairs
// written to consecutive oaram addresses, with entry count and overflow status.
module oa_sparse_encoder #(
  parameter int DATA_WIDTH  = 8,
  parameter int INDEX_WIDTH = 4,
  parameter int ADDR_WIDTH  = 10,
  parameter int MAX_ENTRIES = 1024
) (
  input  logic                clk,
  input  logic                reset,
  oa_sparse_encoder_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ENCODE = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [INDEX_WIDTH-1:0] MAX_RUN   = '1;
  localparam logic [ADDR_WIDTH:0]    MAX_COUNT = (ADDR_WIDTH+1)'(MAX_ENTRIES);

  state_t                  state_r;
  state_t                  state_next_s;
  logic [ADDR_WIDTH-1:0]   wptr_r;
  logic [INDEX_WIDTH-1:0]  run_r;
  logic [INDEX_WIDTH-1:0]  run_next_s;
  logic [ADDR_WIDTH:0]     count_r;
  logic                    overflow_r;
  logic [DATA_WIDTH-1:0]   value_r;
  logic [INDEX_WIDTH-1:0]  index_r;
  logic [ADDR_WIDTH-1:0]   addr_r;
  logic                    we_r;
  logic                    done_r;
  logic                    in_ready_s;
  logic                    start_s;
  logic                    accept_s;
  logic                    emit_s;
  logic                    write_s;
  logic                    suppress_s;
  logic                    last_s;

  // Next-state, handshake and emit decision
  always_comb begin
    state_next_s = state_r;
    in_ready_s   = 1'b0;
    start_s      = 1'b0;
    accept_s     = 1'b0;
    emit_s       = 1'b0;
    run_next_s   = run_r;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          start_s      = 1'b1;
          state_next_s = ENCODE;
        end else begin
          state_next_s = IDLE;
        end
      end
      ENCODE: begin
        in_ready_s = 1'b1;
        accept_s   = bus.in_valid;
        if (bus.in_valid && bus.in_last) begin
          state_next_s = DONE;
        end else begin
          state_next_s = ENCODE;
        end
      end
      DONE: begin
        state_next_s = IDLE;
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase

    // A saturated zero run is written out as a (0, MAX_RUN) entry so the run never wraps
    if (accept_s) begin
      if (bus.in_value != '0) begin
        emit_s     = 1'b1;
        run_next_s = '0;
      end else if (run_r == MAX_RUN) begin
        emit_s     = 1'b1;
        run_next_s = '0;
      end else begin
        run_next_s = run_r + INDEX_WIDTH'(1);
      end
    end else begin
      run_next_s = run_r;
    end

    write_s    = emit_s && (count_r != MAX_COUNT);
    suppress_s = emit_s && (count_r == MAX_COUNT);
    last_s     = accept_s && bus.in_last;
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Tile bookkeeping: write pointer, zero run, entry count and sticky overflow
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_r     <= '0;
      run_r      <= '0;
      count_r    <= '0;
      overflow_r <= 1'b0;
    end else if (start_s) begin
      wptr_r     <= bus.base_addr;
      run_r      <= '0;
      count_r    <= '0;
      overflow_r <= 1'b0;
    end else begin
      run_r <= run_next_s;
      if (write_s) begin
        wptr_r  <= wptr_r + ADDR_WIDTH'(1);
        count_r <= count_r + (ADDR_WIDTH+1)'(1);
      end else begin
        wptr_r  <= wptr_r;
        count_r <= count_r;
      end
      if (suppress_s) begin
        overflow_r <= 1'b1;
      end else begin
        overflow_r <= overflow_r;
      end
    end
  end

  // Registered oaram write port and done strobe
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value_r <= '0;
      index_r <= '0;
      addr_r  <= '0;
      we_r    <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      we_r   <= write_s;
      done_r <= last_s;
      if (write_s) begin
        value_r <= bus.in_value;
        index_r <= run_r;
        addr_r  <= wptr_r;
      end else begin
        value_r <= value_r;
        index_r <= index_r;
        addr_r  <= addr_r;
      end
    end
  end

  assign bus.in_ready            = in_ready_s;
  assign bus.oaram_value         = value_r;
  assign bus.oaram_indices_value = index_r;
  assign bus.oaram_address       = addr_r;
  assign bus.oaram_write_enable  = we_r;
  assign bus.done                = done_r;
  assign bus.entry_count         = count_r;
  assign bus.overflow            = overflow_r;

endmodule

// File: tb/tb_oa_sparse_encoder.sv
// Directed bench for oa_sparse_encoder: expected oaram writes are queued per tile
// and compared as the encoder produces them; done/count/overflow checked at each done.
module tb_oa_sparse_encoder;
  localparam int DW = 8;
  localparam int IW = 4;
  localparam int AW = 10;
  localparam int ME = 4;

  typedef struct packed {
    logic [DW-1:0] v;
    logic [IW-1:0] i;
    logic [AW-1:0] a;
  } wr_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  oa_sparse_encoder_if #(.DATA_WIDTH(DW), .INDEX_WIDTH(IW), .ADDR_WIDTH(AW)) bus ();

  oa_sparse_encoder #(
    .DATA_WIDTH(DW), .INDEX_WIDTH(IW), .ADDR_WIDTH(AW), .MAX_ENTRIES(ME)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  wr_t         exp_q[$];
  wr_t         mon_e;
  int          n_assert = 0;
  int          n_fail   = 0;
  int          done_cnt = 0;
  logic [AW:0] exp_count = '0;
  logic        exp_ovf = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic exp_wr(input logic [DW-1:0] v, input logic [IW-1:0] i, input logic [AW-1:0] a);
    wr_t w;
    w.v = v;
    w.i = i;
    w.a = a;
    exp_q.push_back(w);
  endtask

  task automatic start_tile(input logic [AW-1:0] base, input logic [AW:0] cnt, input logic ovf);
    exp_count = cnt;
    exp_ovf   = ovf;
    @(negedge clk);
    bus.start     = 1'b1;
    bus.base_addr = base;
    @(negedge clk);
    bus.start     = 1'b0;
    bus.base_addr = '0;
  endtask

  task automatic beat(input logic [DW-1:0] v, input logic last, input logic valid);
    bus.in_valid = valid;
    bus.in_value = v;
    bus.in_last  = last;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_value = '0;
    bus.in_last  = 1'b0;
  endtask

  task automatic wait_done(input int target);
    for (int k = 0; k < 20; k++) begin
      if (done_cnt >= target) break;
      @(posedge clk);
    end
    check("done_seen", done_cnt, target);
  endtask

  // Scoreboard: pop an expected write per strobe, check status on each done
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.oaram_write_enable) begin
        check("write_expected", (exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          check("wr_value", bus.oaram_value, mon_e.v);
          check("wr_index", bus.oaram_indices_value, mon_e.i);
          check("wr_addr", bus.oaram_address, mon_e.a);
        end
      end
      if (bus.done) begin
        check("writes_pending_at_done", exp_q.size(), 32'd0);
        check("entry_count", bus.entry_count, exp_count);
        check("overflow_at_done", bus.overflow, exp_ovf);
        done_cnt++;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int d0;
    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.base_addr = '0;
    bus.in_valid  = 1'b0;
    bus.in_value  = '0;
    bus.in_last   = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", bus.in_ready, 32'd0);
    check("rst_we", bus.oaram_write_enable, 32'd0);
    check("rst_done", bus.done, 32'd0);
    check("rst_overflow", bus.overflow, 32'd0);
    check("rst_entry_count", bus.entry_count, 32'd0);
    reset = 1'b0;

    // Basic pairs: 5,0,0,7
    start_tile(10'h010, 11'd2, 1'b0);
    check("in_ready_encode", bus.in_ready, 32'd1);
    exp_wr(8'd5, 4'd0, 10'h010);
    exp_wr(8'd7, 4'd2, 10'h011);
    beat(8'd5, 1'b0, 1'b1);
    beat(8'd0, 1'b0, 1'b1);
    beat(8'd0, 1'b0, 1'b1);
    beat(8'd7, 1'b1, 1'b1);
    wait_done(1);

    // 17 zeros then 9: saturated run written as a (0, MAX_RUN) entry
    start_tile(10'h020, 11'd2, 1'b0);
    exp_wr(8'd0, 4'd15, 10'h020);
    exp_wr(8'd9, 4'd1, 10'h021);
    for (int k = 0; k < 17; k++) beat(8'd0, 1'b0, 1'b1);
    beat(8'd9, 1'b1, 1'b1);
    wait_done(2);
    check("in_ready_after_done", bus.in_ready, 32'd0);

    // Trailing zeros dropped
    start_tile(10'h030, 11'd1, 1'b0);
    exp_wr(8'd3, 4'd0, 10'h030);
    beat(8'd3, 1'b0, 1'b1);
    beat(8'd0, 1'b0, 1'b1);
    beat(8'd0, 1'b0, 1'b1);
    beat(8'd0, 1'b1, 1'b1);
    wait_done(3);

    // All-zero tile
    start_tile(10'h040, 11'd0, 1'b0);
    for (int k = 0; k < 3; k++) beat(8'd0, 1'b0, 1'b1);
    beat(8'd0, 1'b1, 1'b1);
    wait_done(4);

    // Capacity overflow with address wrap
    start_tile(10'h3FE, 11'd4, 1'b1);
    exp_wr(8'd1, 4'd0, 10'h3FE);
    exp_wr(8'd2, 4'd0, 10'h3FF);
    exp_wr(8'd3, 4'd0, 10'h000);
    exp_wr(8'd4, 4'd0, 10'h001);
    for (int k = 1; k <= 5; k++) beat(8'(k), 1'b0, 1'b1);
    beat(8'd6, 1'b1, 1'b1);
    wait_done(5);
    @(negedge clk);
    check("entry_count_held", bus.entry_count, 32'd4);
    check("overflow_sticky", bus.overflow, 32'd1);

    // Gapped valid and an ignored mid-tile start
    start_tile(10'h100, 11'd2, 1'b0);
    check("overflow_cleared", bus.overflow, 32'd0);
    exp_wr(8'd4, 4'd0, 10'h100);
    exp_wr(8'd6, 4'd1, 10'h101);
    beat(8'd4, 1'b0, 1'b1);
    bus.start     = 1'b1;
    bus.base_addr = 10'h200;
    beat(8'd0, 1'b0, 1'b0);
    bus.start     = 1'b0;
    bus.base_addr = '0;
    beat(8'd0, 1'b0, 1'b1);
    beat(8'd0, 1'b0, 1'b0);
    beat(8'd6, 1'b1, 1'b1);
    wait_done(6);

    // Reset two beats into a tile, then a fresh tile
    start_tile(10'h050, 11'd0, 1'b0);
    beat(8'd0, 1'b0, 1'b1);
    beat(8'd0, 1'b0, 1'b1);
    d0    = done_cnt;
    reset = 1'b1;
    #1;
    check("mid_rst_in_ready", bus.in_ready, 32'd0);
    check("mid_rst_we", bus.oaram_write_enable, 32'd0);
    check("mid_rst_value", bus.oaram_value, 32'd0);
    check("mid_rst_index", bus.oaram_indices_value, 32'd0);
    check("mid_rst_addr", bus.oaram_address, 32'd0);
    check("mid_rst_entry_count", bus.entry_count, 32'd0);
    check("mid_rst_done", bus.done, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("no_done_after_rst", done_cnt, d0);
    start_tile(10'h060, 11'd1, 1'b0);
    exp_wr(8'd8, 4'd0, 10'h060);
    beat(8'd8, 1'b1, 1'b1);
    wait_done(d0 + 1);
    repeat (2) @(negedge clk);
    check("queue_drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
